// File: rtl/mt_fetch_pkg.sv
// Shared types and PC-tagging helper for the multithreaded fetch unit.
package mt_fetch_pkg;

    localparam int unsigned PC_MAX_W = 64;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_IDLE = 1'b1
    } fetch_state_e;

    // Replace the top tid_w bits of an addr_w-bit PC with the thread tag.
    function automatic logic [PC_MAX_W-1:0] tag_pc(
        input logic [PC_MAX_W-1:0] pc,
        input logic [PC_MAX_W-1:0] tag,
        input int unsigned         addr_w,
        input int unsigned         tid_w
    );
        logic [PC_MAX_W-1:0] low_mask;
        low_mask = (PC_MAX_W'(1) << (addr_w - tid_w)) - PC_MAX_W'(1);
        return (pc & low_mask) | (tag << (addr_w - tid_w));
    endfunction

endpackage

// File: rtl/mt_fetch_unit_rr_thread_picker.sv
// Combinational round-robin thread picker: searches cur+1 upward with wrap,
// the current thread considered last.
module rr_thread_picker
    import mt_fetch_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 2
) (
    input  logic [NUM_THREADS-1:0]         mask_i,
    input  logic [$clog2(NUM_THREADS)-1:0] cur_id_i,
    output logic [$clog2(NUM_THREADS)-1:0] pick_id_c,
    output logic                           found_c
);

    localparam int unsigned TID_W = $clog2(NUM_THREADS);

    always_comb begin
        logic [TID_W-1:0] idx;
        pick_id_c = cur_id_i;
        found_c   = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
            idx = cur_id_i + TID_W'(k);
            if (!found_c && mask_i[idx]) begin
                found_c   = 1'b1;
                pick_id_c = idx;
            end
        end
    end

endmodule

// File: rtl/mt_fetch_unit.sv
// Multithreaded fetch PC unit: per-thread PC file, round-robin thread switch, IDLE when
// nothing is runnable. Define MT_FETCH_TIMESLICE_EN to add quantum-based forced switches.
module mt_fetch_unit
    import mt_fetch_pkg::*;
#(
    parameter int unsigned           NUM_THREADS = 2,
    parameter int unsigned           ADDR_WIDTH  = 26,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
`ifdef MT_FETCH_TIMESLICE_EN
    ,
    parameter int unsigned           QUANTUM     = 64
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_stall,
    input  logic                           i_load_pc_we,
    input  logic [ADDR_WIDTH-1:0]          i_load_pc_new_pc,
    input  logic                           i_bp_is_branch,
    input  logic                           i_bp_prediction,
    input  logic [ADDR_WIDTH-1:0]          i_bp_target,
    input  logic                           i_switch_req,
    input  logic [ADDR_WIDTH-1:0]          i_resume_pc,
    input  logic [NUM_THREADS-1:0]         i_thread_ready,
    output logic [ADDR_WIDTH-1:0]          o_pc_current,
    output logic [ADDR_WIDTH-1:0]          o_pc_next,
    output logic [$clog2(NUM_THREADS)-1:0] o_thread_id,
    output logic                           o_switch,
    output logic                           o_idle
);

    localparam int unsigned TID_W = $clog2(NUM_THREADS);

    function automatic logic [ADDR_WIDTH-1:0] tag_pc_w(input logic [ADDR_WIDTH-1:0] pc,
                                                        input logic [TID_W-1:0]      tid);
        return ADDR_WIDTH'(tag_pc(PC_MAX_W'(pc), PC_MAX_W'(tid), ADDR_WIDTH, TID_W));
    endfunction

    fetch_state_e          state_q, state_d;
    logic [TID_W-1:0]      tid_q, tid_d, pick_id;
    logic                  pick_found;
    logic [ADDR_WIDTH-1:0] pc_q, pc_next_c, resume_pc;
    logic [ADDR_WIDTH-1:0] pc_file_q [NUM_THREADS];
    logic [ADDR_WIDTH-1:0] pc_file_d [NUM_THREADS];
    logic                  switch_q, switch_d, idle_q, idle_d;
    logic                  switch_take, slice_expire;

    rr_thread_picker #(
        .NUM_THREADS(NUM_THREADS)
    ) u_picker (
        .mask_i   (i_thread_ready),
        .cur_id_i (tid_q),
        .pick_id_c(pick_id),
        .found_c  (pick_found)
    );

`ifdef MT_FETCH_TIMESLICE_EN
    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);

    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;

    // Only productive (non-stalled) cycles consume the quantum.
    assign slice_expire = (state_q == ST_RUN) && !i_stall &&
                          (slice_cnt_q == CNT_W'(QUANTUM - 1));

    always_comb begin
        slice_cnt_d = slice_cnt_q;
        if ((state_q != ST_RUN) || switch_take) begin
            slice_cnt_d = '0;
        end else if (!i_stall) begin
            slice_cnt_d = slice_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_cnt_q <= '0;
        end else begin
            slice_cnt_q <= slice_cnt_d;
        end
    end
`else
    assign slice_expire = 1'b0;
`endif

    // External request wins over the quantum and brings its own resume PC.
    assign switch_take = i_switch_req || slice_expire;
    assign resume_pc   = i_switch_req ? i_resume_pc : pc_q;

    always_comb begin
        state_d   = state_q;
        tid_d     = tid_q;
        pc_next_c = pc_q;
        switch_d  = 1'b0;
        idle_d    = idle_q;
        pc_file_d = pc_file_q;
        case (state_q)
            ST_RUN: begin
                if (switch_take) begin
                    pc_file_d[tid_q] = tag_pc_w(resume_pc, tid_q);
                    if (pick_found) begin
                        tid_d     = pick_id;
                        switch_d  = 1'b1;
                        pc_next_c = (pick_id == tid_q) ? tag_pc_w(resume_pc, tid_q)
                                                       : tag_pc_w(pc_file_q[pick_id], pick_id);
                    end else begin
                        state_d = ST_IDLE;
                        idle_d  = 1'b1;
                    end
                end else if (i_stall) begin
                    pc_next_c = pc_q;
                end else if (i_load_pc_we) begin
                    pc_next_c = tag_pc_w(i_load_pc_new_pc, tid_q);
                end else if (i_bp_is_branch && i_bp_prediction) begin
                    pc_next_c = tag_pc_w(i_bp_target, tid_q);
                end else begin
                    pc_next_c = tag_pc_w(pc_q + ADDR_WIDTH'(4), tid_q);
                end
            end
            ST_IDLE: begin
                if (pick_found) begin
                    tid_d     = pick_id;
                    pc_next_c = tag_pc_w(pc_file_q[pick_id], pick_id);
                    state_d   = ST_RUN;
                    switch_d  = 1'b1;
                    idle_d    = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            tid_q    <= '0;
            pc_q     <= tag_pc_w(RESET_PC, '0);
            switch_q <= 1'b0;
            idle_q   <= 1'b0;
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                pc_file_q[t] <= tag_pc_w(RESET_PC, TID_W'(t));
            end
        end else begin
            state_q   <= state_d;
            tid_q     <= tid_d;
            pc_q      <= pc_next_c;
            switch_q  <= switch_d;
            idle_q    <= idle_d;
            pc_file_q <= pc_file_d;
        end
    end

    assign o_pc_current = pc_q;
    assign o_pc_next    = pc_next_c;
    assign o_thread_id  = tid_q;
    assign o_switch     = switch_q;
    assign o_idle       = idle_q;

endmodule
